trig_sequencer: RTL and testbench

Parametrised successor to the fixed 8-level capture trigger. Evaluates a programmable chain of up to STAGES trigger stages against the sampled input. Each stage has mask/type/level qualifiers and a match-count requirement. Sits between the sampler and the sample buffer: it drives circular-buffer write addressing, latches the trigger position and counts post-trigger samples.

---
 rtl/logicap_pkg.sv | 31 +++
 rtl/trig_stage_match.sv | 43 ++++
 rtl/trig_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_trig_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicap_pkg.sv
// Shared definitions for the trigger sequencer: FSM state type, per-bit
// qualifier encodings and the circular-buffer address wrap helper.
package logicap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Per-bit qualifier type (trig_type bit value)
  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  // Edge direction carried on the level bit when the type is TRIG_EDGE
  localparam logic EDGE_RISING = 1'b1;

  // Next circular-buffer address. A depth of 0 stands for a full
  // 2^aw-entry buffer. An address already past a shrunken depth folds to 0.
  function automatic logic [31:0] buf_next_addr(input logic [31:0]  addr,
                                                input logic [31:0]  depth,
                                                input int unsigned  aw);
    logic [32:0] nxt;
    logic [32:0] lim;
    nxt = {1'b0, addr} + 33'd1;
    lim = (depth == 32'd0) ? (33'd1 << aw) : {1'b0, depth};
    return (nxt >= lim) ? 32'd0 : nxt[31:0];
  endfunction

endpackage

// File: rtl/trig_stage_match.sv
// Combinational match of one sample against one trigger stage.
// Ports:
//   din_i        current sample
//   prev_i       previous accepted sample
//   prev_valid_i prev_i holds a real sample (edge qualifiers need it)
//   mask_i       per-bit enable; unmasked bits always qualify
//   type_i       per-bit TRIG_LEVEL / TRIG_EDGE
//   level_i      level: required value; edge: EDGE_RISING or falling
//   match_o      every enabled bit qualifies
module trig_stage_match
  import logicap_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] din_i,
  input  logic [SIZE-1:0] prev_i,
  input  logic            prev_valid_i,
  input  logic [SIZE-1:0] mask_i,
  input  logic [SIZE-1:0] type_i,
  input  logic [SIZE-1:0] level_i,
  output logic            match_o
);

  logic [SIZE-1:0] bit_ok;

  always_comb begin
    bit_ok = '1;
    for (int b = 0; b < SIZE; b++) begin
      if (mask_i[b]) begin
        if (type_i[b] == TRIG_EDGE) begin
          if (level_i[b] == EDGE_RISING)
            bit_ok[b] = prev_valid_i && !prev_i[b] && din_i[b];
          else
            bit_ok[b] = prev_valid_i && prev_i[b] && !din_i[b];
        end else begin
          bit_ok[b] = (din_i[b] == level_i[b]);
        end
      end
    end
    match_o = &bit_ok;
  end

endmodule

// File: rtl/trig_sequencer.sv
// Multi-stage capture trigger. Walks a programmable chain of stages over the
// sampled input, writes every accepted sample into a circular buffer, latches
// the buffer address of the trigger sample and collects post-trigger samples.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   din, din_valid               sample stream
//   arm, abort                   control pulses
//   num_stages .. buffer_size    live configuration (stable while not idle)
//   wr_en, wr_addr, wr_data      registered buffer write port
//   ready, armed, triggered, done, cur_stage, trigger_pos   status
module trig_sequencer
  import logicap_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int STAGES  = 8,
  parameter int CNT_W   = 16,
  parameter int SADDR_W = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SIZE-1:0]             din,
  input  logic                        din_valid,
  input  logic                        arm,
  input  logic                        abort,
  input  logic [$clog2(STAGES):0]     num_stages,
  input  logic [STAGES*SIZE-1:0]      trig_mask,
  input  logic [STAGES*SIZE-1:0]      trig_type,
  input  logic [STAGES*SIZE-1:0]      trig_level,
  input  logic [STAGES*CNT_W-1:0]     stage_count,
  input  logic [SADDR_W-1:0]          post_trigger_count,
  input  logic [SADDR_W-1:0]          buffer_size,
  output logic                        wr_en,
  output logic [SADDR_W-1:0]          wr_addr,
  output logic [SIZE-1:0]             wr_data,
  output logic                        ready,
  output logic                        armed,
  output logic                        triggered,
  output logic                        done,
  output logic [$clog2(STAGES)-1:0]   cur_stage,
  output logic [SADDR_W-1:0]          trigger_pos
);

  localparam int STG_W = $clog2(STAGES);
  localparam int NS_W  = STG_W + 1;

  seq_state_e         state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic [SADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE-1:0]    wr_data_q, wr_data_d;
  logic [SADDR_W-1:0] addr_q, addr_d;        // address the next sample goes to
  logic [STG_W-1:0]   cur_stage_q, cur_stage_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [SIZE-1:0]    prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [SADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [SADDR_W-1:0] post_cnt_q, post_cnt_d;

  logic [SIZE-1:0]    stg_mask, stg_type, stg_level;
  logic [CNT_W-1:0]   stg_cnt;
  logic [CNT_W:0]     cnt_inc;
  logic [NS_W-1:0]    ns_eff;
  logic [STG_W-1:0]   last_stage;
  logic [SADDR_W-1:0] addr_inc;
  logic               match;
  logic               accept;
  logic               start;

  always_comb begin
    stg_mask  = trig_mask[int'(cur_stage_q)*SIZE +: SIZE];
    stg_type  = trig_type[int'(cur_stage_q)*SIZE +: SIZE];
    stg_level = trig_level[int'(cur_stage_q)*SIZE +: SIZE];
    stg_cnt   = stage_count[int'(cur_stage_q)*CNT_W +: CNT_W];
    if (num_stages == '0)
      ns_eff = NS_W'(1);
    else if (int'(num_stages) > STAGES)
      ns_eff = NS_W'(STAGES);
    else
      ns_eff = num_stages;
    last_stage = STG_W'(ns_eff - NS_W'(1));
    addr_inc   = SADDR_W'(buf_next_addr(32'(addr_q), 32'(buffer_size), SADDR_W));
    cnt_inc    = {1'b0, match_cnt_q} + (CNT_W+1)'(1);
  end

  trig_stage_match #(.SIZE(SIZE)) u_match (
    .din_i        (din),
    .prev_i       (prev_q),
    .prev_valid_i (prev_valid_q),
    .mask_i       (stg_mask),
    .type_i       (stg_type),
    .level_i      (stg_level),
    .match_o      (match)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_d       = addr_q;
    cur_stage_d  = cur_stage_q;
    match_cnt_d  = match_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_pos_d   = trig_pos_q;
    post_cnt_d   = post_cnt_q;
    accept       = 1'b0;
    start        = 1'b0;

    unique case (state_q)
      IDLE: if (arm) start = 1'b1;
      SEQ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (din_valid) begin
          accept       = 1'b1;
          prev_d       = din;
          prev_valid_d = 1'b1;
          if (match) begin
            // stage_count of 0 passes on the first match, same as 1
            if (cnt_inc >= {1'b0, stg_cnt}) begin
              match_cnt_d = '0;
              if (cur_stage_q == last_stage) begin
                trig_pos_d = addr_q;
                post_cnt_d = '0;
                state_d    = (post_trigger_count == '0) ? DONE : POST;
              end else begin
                cur_stage_d = cur_stage_q + STG_W'(1);
              end
            end else begin
              match_cnt_d = cnt_inc[CNT_W-1:0];
            end
          end
        end
      end
      POST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (post_cnt_q == post_trigger_count) begin
          // DONE follows the cycle that shows the last write
          state_d = DONE;
        end else if (din_valid) begin
          accept     = 1'b1;
          post_cnt_d = post_cnt_q + SADDR_W'(1);
        end
      end
      DONE: begin
        if (abort)
          state_d = IDLE;
        else if (arm)
          start = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = din;
      addr_d    = addr_inc;
    end

    if (start) begin
      state_d      = SEQ;
      wr_addr_d    = '0;
      addr_d       = '0;
      cur_stage_d  = '0;
      match_cnt_d  = '0;
      prev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_q       <= '0;
      cur_stage_q  <= '0;
      match_cnt_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_pos_q   <= '0;
      post_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_q       <= addr_d;
      cur_stage_q  <= cur_stage_d;
      match_cnt_q  <= match_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_pos_q   <= trig_pos_d;
      post_cnt_q   <= post_cnt_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign ready       = (state_q == IDLE);
  assign armed       = (state_q == SEQ);
  assign triggered   = (state_q == POST) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign cur_stage   = cur_stage_q;
  assign trigger_pos = trig_pos_q;

endmodule

// File: tb/tb_trig_sequencer.sv
module tb_trig_sequencer;
  localparam int SIZE    = 32;
  localparam int STAGES  = 8;
  localparam int CNT_W   = 16;
  localparam int SADDR_W = 24;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [SIZE-1:0]           din;
  logic                      din_valid;
  logic                      arm;
  logic                      abort;
  logic [3:0]                num_stages;
  logic [STAGES*SIZE-1:0]    trig_mask;
  logic [STAGES*SIZE-1:0]    trig_type;
  logic [STAGES*SIZE-1:0]    trig_level;
  logic [STAGES*CNT_W-1:0]   stage_count;
  logic [SADDR_W-1:0]        post_trigger_count;
  logic [SADDR_W-1:0]        buffer_size;
  logic                      wr_en;
  logic [SADDR_W-1:0]        wr_addr;
  logic [SIZE-1:0]           wr_data;
  logic                      ready;
  logic                      armed;
  logic                      triggered;
  logic                      done;
  logic [2:0]                cur_stage;
  logic [SADDR_W-1:0]        trigger_pos;

  logic [SIZE-1:0]  cfg_mask  [STAGES];
  logic [SIZE-1:0]  cfg_type  [STAGES];
  logic [SIZE-1:0]  cfg_level [STAGES];
  logic [CNT_W-1:0] cfg_cnt   [STAGES];
  logic [SIZE-1:0]  smp[$];

  int total = 0;
  int bad = 0;

  longint cyc = 0;
  logic [SADDR_W-1:0] log_addr[$];
  logic [SIZE-1:0]    log_data[$];
  longint             log_cyc[$];
  longint             done_rise_cyc = -1;
  bit                 done_seen = 1'b0;

  trig_sequencer #(.SIZE(SIZE), .STAGES(STAGES), .CNT_W(CNT_W), .SADDR_W(SADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .arm(arm), .abort(abort),
    .num_stages(num_stages), .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
    .stage_count(stage_count), .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready), .armed(armed),
    .triggered(triggered), .done(done), .cur_stage(cur_stage), .trigger_pos(trigger_pos)
  );

  always #5 clk = ~clk;

  always_comb begin
    trig_mask = '0; trig_type = '0; trig_level = '0; stage_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      trig_mask[i*SIZE +: SIZE]    = cfg_mask[i];
      trig_type[i*SIZE +: SIZE]    = cfg_type[i];
      trig_level[i*SIZE +: SIZE]   = cfg_level[i];
      stage_count[i*CNT_W +: CNT_W] = cfg_cnt[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (done && !done_seen) done_rise_cyc = cyc;
    done_seen = done;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < STAGES; i++) begin
      cfg_mask[i] = '0; cfg_type[i] = '0; cfg_level[i] = '0; cfg_cnt[i] = '0;
    end
    num_stages = 4'd1;
    post_trigger_count = '0;
    buffer_size = '0;
  endtask

  // Reference: does sample d satisfy stage s, judging bit by bit
  function automatic bit sample_matches(input logic [SIZE-1:0] d, input logic [SIZE-1:0] p,
                                        input bit pv, input int s);
    for (int b = 0; b < SIZE; b++) begin
      if (cfg_mask[s][b]) begin
        if (cfg_type[s][b]) begin
          if (!pv) return 1'b0;
          if (cfg_level[s][b] && !(p[b] == 1'b0 && d[b] == 1'b1)) return 1'b0;
          if (!cfg_level[s][b] && !(p[b] == 1'b1 && d[b] == 1'b0)) return 1'b0;
        end else if (d[b] != cfg_level[s][b]) begin
          return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  // Reference: index of the trigger sample among the first n samples, or -1
  function automatic int model_trig(input int n, output int end_stage);
    int eff, stage, cnt, need;
    logic [SIZE-1:0] p;
    bit pv;
    eff = (num_stages == 0) ? 1 : ((int'(num_stages) > STAGES) ? STAGES : int'(num_stages));
    stage = 0; cnt = 0; p = '0; pv = 1'b0; end_stage = 0;
    for (int i = 0; i < n; i++) begin
      if (sample_matches(smp[i], p, pv, stage)) begin
        cnt++;
        need = (cfg_cnt[stage] == 0) ? 1 : int'(cfg_cnt[stage]);
        if (cnt >= need) begin
          cnt = 0;
          if (stage == eff - 1) begin
            end_stage = stage;
            return i;
          end
          stage++;
        end
      end
      p = smp[i];
      pv = 1'b1;
    end
    end_stage = stage;
    return -1;
  endfunction

  task automatic feed(input logic [SIZE-1:0] d);
    din = d; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic run_capture(input string name, input int gap_max, input bit leave_done);
    int n, t, end_stage, start, exp_n, got_n, post, depth;
    bit exp_done;
    n = smp.size();
    t = model_trig(n, end_stage);
    post = int'(post_trigger_count);
    depth = (buffer_size == 0) ? (1 << SADDR_W) : int'(buffer_size);
    exp_done = (t >= 0) && (t + post < n);
    exp_n = (t < 0) ? n : (exp_done ? t + post + 1 : n);
    start = log_addr.size();
    pulse_arm();
    foreach (smp[i]) begin
      feed(smp[i]);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    got_n = log_addr.size() - start;
    chk({name, " write count"}, 64'(got_n), 64'(exp_n));
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      chk({name, " wr_addr"}, 64'(log_addr[start+i]), 64'(i % depth));
      chk({name, " wr_data"}, 64'(log_data[start+i]), 64'(smp[i]));
    end
    if (t >= 0) begin
      chk({name, " trigger_pos"}, 64'(trigger_pos), 64'(t % depth));
      chk({name, " triggered"}, 64'(triggered), 64'(1));
      chk({name, " done"}, 64'(done), 64'(exp_done));
      if (exp_done && got_n > 0)
        chk({name, " done latency"}, 64'(done_rise_cyc - log_cyc[log_cyc.size()-1]),
            64'((post == 0) ? 0 : 1));
    end else begin
      chk({name, " armed"}, 64'(armed), 64'(1));
      chk({name, " cur_stage"}, 64'(cur_stage), 64'(end_stage));
    end
    if (!(leave_done && exp_done)) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({name, " ready after abort"}, 64'(ready), 64'(1));
      chk({name, " triggered after abort"}, 64'(triggered), 64'(0));
      if (t >= 0) chk({name, " trigger_pos held"}, 64'(trigger_pos), 64'(t % depth));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; din = '0; din_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg_clear();
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(ready), 64'(1));
    chk("reset wr_en", 64'(wr_en), 64'(0));
    chk("reset armed", 64'(armed), 64'(0));
    chk("reset triggered", 64'(triggered), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset wr_addr", 64'(wr_addr), 64'(0));
    chk("reset trigger_pos", 64'(trigger_pos), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // single-stage level trigger on bit0
    cfg_clear();
    cfg_mask[0] = 32'h1; cfg_level[0] = 32'h1; cfg_cnt[0] = 16'd1;
    post_trigger_count = 24'd4; buffer_size = 24'd128;
    smp = {32'd0, 32'd2, 32'd4, 32'd1, 32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15};
    run_capture("lvl1", 0, 1'b1);
    chk("lvl1 trigger_pos fixed", 64'(trigger_pos), 64'(3));
    run_capture("lvl1 rearm", 2, 1'b0);

    // three-stage sequence: rise bit0, fall bit1, three bit2 highs
    cfg_clear();
    num_stages = 4'd3;
    cfg_mask[0] = 32'h1; cfg_type[0] = 32'h1; cfg_level[0] = 32'h1;
    cfg_mask[1] = 32'h2; cfg_type[1] = 32'h2; cfg_level[1] = 32'h0;
    cfg_mask[2] = 32'h4; cfg_level[2] = 32'h4; cfg_cnt[2] = 16'd3;
    post_trigger_count = 24'd2; buffer_size = 24'd64;
    smp = {32'h4, 32'h4, 32'h1, 32'h4};
    run_capture("seq3 part1", 1, 1'b0);
    smp = {32'h4, 32'h4, 32'h1, 32'h4, 32'h2, 32'h0};
    run_capture("seq3 part2", 1, 1'b0);
    smp = {32'h4, 32'h4, 32'h1, 32'h4, 32'h2, 32'h0, 32'h4, 32'h0, 32'h4, 32'h1, 32'h4, 32'h0, 32'h0};
    run_capture("seq3 full", 1, 1'b0);
    chk("seq3 trigger_pos fixed", 64'(trigger_pos), 64'(10));

    // wrap on an 8-deep buffer
    cfg_clear();
    cfg_mask[0] = 32'h100; cfg_level[0] = 32'h100;
    post_trigger_count = 24'd3; buffer_size = 24'd8;
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(32'(i & 'hF));
    smp.push_back(32'h100);
    for (int i = 0; i < 5; i++) smp.push_back(32'h0);
    run_capture("wrap", 1, 1'b0);
    chk("wrap trigger_pos fixed", 64'(trigger_pos), 64'(4));

    // rising edge not seen on the first sample after arm
    cfg_clear();
    cfg_mask[0] = 32'h1; cfg_type[0] = 32'h1; cfg_level[0] = 32'h1;
    post_trigger_count = 24'd2; buffer_size = 24'd16;
    smp = {32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0};
    run_capture("edge first", 0, 1'b0);
    chk("edge first trigger_pos fixed", 64'(trigger_pos), 64'(3));

    // randomized configurations
    for (int r = 0; r < 24; r++) begin
      cfg_clear();
      num_stages = 4'($urandom_range(0, 9));
      for (int s = 0; s < STAGES; s++) begin
        cfg_mask[s]  = $urandom & 32'hF;
        cfg_type[s]  = $urandom & 32'hF;
        cfg_level[s] = $urandom & 32'hF;
        cfg_cnt[s]   = CNT_W'($urandom_range(0, 3));
      end
      post_trigger_count = SADDR_W'($urandom_range(0, 5));
      buffer_size = (r % 5 == 0) ? '0 : SADDR_W'($urandom_range(1, 12));
      smp.delete();
      for (int i = 0; i < int'($urandom_range(10, 60)); i++) smp.push_back($urandom & 32'hF);
      run_capture($sformatf("rand%0d", r), 2, (r % 2) == 1);
      if (done) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end

    // abort with simultaneous arm while collecting post-trigger samples
    cfg_clear();
    cfg_mask[0] = 32'h1; cfg_level[0] = 32'h1;
    post_trigger_count = 24'd10; buffer_size = 24'd128;
    pulse_arm();
    feed(32'h0); feed(32'h1); feed(32'h0);
    chk("abort pre triggered", 64'(triggered), 64'(1));
    abort = 1'b1; arm = 1'b1; din = 32'h7; din_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; arm = 1'b0; din_valid = 1'b0;
    chk("abort ready", 64'(ready), 64'(1));
    chk("abort armed", 64'(armed), 64'(0));
    chk("abort triggered", 64'(triggered), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort wr_en", 64'(wr_en), 64'(0));
    chk("abort trigger_pos", 64'(trigger_pos), 64'(1));

    // asynchronous reset in the middle of POST
    pulse_arm();
    feed(32'h0); feed(32'h0); feed(32'h1); feed(32'h2);
    #3 reset_n = 1'b0;
    #1;
    chk("async rst ready", 64'(ready), 64'(1));
    chk("async rst triggered", 64'(triggered), 64'(0));
    chk("async rst wr_en", 64'(wr_en), 64'(0));
    chk("async rst wr_addr", 64'(wr_addr), 64'(0));
    chk("async rst wr_data", 64'(wr_data), 64'(0));
    chk("async rst trigger_pos", 64'(trigger_pos), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    post_trigger_count = 24'd3;
    smp = {32'h2, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0};
    run_capture("after reset", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
